exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception/ERET sequencer sitting between the MEM stage and the CP0 register file. It arbitrates all exception requests of the committing instruction by MIPS priority, issues a single-cycle CP0 update (EPC, BD, ExcCode, BadVAddr, EXL), flushes the pipeline, then redirects fetch through a valid/ready handshake. It is the only agent allowed to change EXL and EPC outside MTC0.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC
- RST_PC, 32'hBFC0_0000, unused by logic; documents boot vector for the bench

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc  in  32  PC of MEM instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_addr  in  32  data address of MEM load/store
- req_int  in  1  interrupt pending (IP&IM, IE already applied upstream)
- req_adel_if  in  1  fetch address error (mem_pc[1:0]!=0)
- req_ri, req_ov, req_sys, req_bp  in  1 each  reserved instr / overflow / syscall / break
- req_adel, req_ades  in  1 each  data load / store address error
- mem_eret  in  1  MEM instruction is ERET
- exl  in  1  current Status.EXL
- epc_in  in  32  current EPC (ERET target)
- exc_hit  out  1  combinational: exception or ERET accepted this cycle (stalls IF/ID/EX)
- busy  out  1  state != IDLE
- flush  out  1  kill all stages IF..MEM
- cp0_we  out  1  one-cycle CP0 update strobe
- cp0_exccode  out  5  Cause.ExcCode value
- cp0_epc  out  32  value for EPC
- cp0_bd  out  1  value for Cause.BD
- cp0_epc_we  out  1  write EPC/BD (0 when exl was 1)
- cp0_badv_we  out  1  write BadVAddr
- cp0_badvaddr  out  32  value for BadVAddr
- cp0_set_exl, cp0_clr_exl  out  1 each  EXL set / clear, qualified by cp0_we
- redirect_valid  out  1  new PC offered to fetch
- redirect_pc  out  32  new fetch PC
- redirect_ready  in  1  fetch accepts redirect_pc

## Operation
- States: IDLE, FLUSH, REDIRECT.
- IDLE: accept iff mem_valid and (any req_* or mem_eret). req_int ignored when exl=1; other requests taken regardless of exl.
- Priority (high→low): int(0), adel_if(4), ri(10), ov(12), sys(8), bp(9), adel(4), ades(5); ERET lowest (only if no request).
- Captured on accept: exccode, epc = mem_bd ? mem_pc-4 : mem_pc (mod 2^32), bd = mem_bd, badvaddr = adel_if ? mem_pc : mem_addr, badv_we = adel_if|adel|ades of the winner, epc_we = ~exl, target = EXC_VECTOR (exception) or epc_in (ERET).
- FLUSH: cp0_we=1, flush=1; exception → cp0_set_exl=1; ERET → cp0_clr_exl=1, epc_we=0, badv_we=0. Next: REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target held stable; flush=1 held. On redirect_ready=1 → IDLE.
- Requests arriving while busy are ignored (they belong to flushed instructions).
- mem_valid=0 → no accept even if req_* high.

## Timing
- Accept in cycle T (exc_hit=1 combinationally); FLUSH in T+1; REDIRECT from T+2; earliest return to IDLE after T+2 edge when ready already high. Minimum occupancy 2 cycles.
- redirect_ready sampled only in REDIRECT; ready high in other states has no effect.
- cp0_we high exactly one cycle per accept; never two consecutive cycles.
- Reset (any state, including mid-REDIRECT): next cycle IDLE; all outputs 0, redirect_pc=0, captured registers 0. exc_hit is 0 while rst=1.
- Simultaneous int + eret: interrupt wins, EPC = mem_pc of the ERET.

## Structure
- Shared package exc_defs: ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), state encoding (IDLE=0, FLUSH=1, REDIRECT=2), EXC_VECTOR default.
- One sub-module: exc_prio_enc — combinational priority encoder, req vector → {hit, exccode, badv_sel}.

## Test plan
- Overflow at mem_pc=0x8000_0010, bd=0, exl=0 -> T+1 cp0_we, exccode=12, epc=0x8000_0010, set_exl; T+2 redirect_pc=0xBFC0_0380.
- Load misaligned in delay slot, mem_pc=0x8000_0024, addr=0x1003 -> exccode=4, epc=0x8000_0020, bd=1, badvaddr=0x1003, badv_we=1.
- req_int+req_sys+req_ri together -> exccode=0; with exl=1 same inputs -> exccode=10, epc_we=0.
- ERET with epc_in=0x8000_0100 -> clr_exl, epc_we=0, redirect_pc=0x8000_0100.
- redirect_ready low 5 cycles -> redirect_valid/pc stable, new req_sys ignored, single cp0_we.
- rst asserted during REDIRECT -> next cycle all outputs 0, state IDLE; later fresh sys at mem_pc=0x40 taken normally.

Source files
------------

// File: rtl/exc_defs.sv
// Shared definitions for the exception/ERET sequencer: Cause.ExcCode values,
// sequencer state encoding and the default exception entry vector.
package exc_defs;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational MIPS exception priority encoder for the committing instruction.
// badv_sel[1] = winner writes BadVAddr, badv_sel[0] = BadVAddr comes from the PC.
module exc_prio_enc
    import exc_defs::*;
(
    input  logic       req_int,
    input  logic       req_adel_if,
    input  logic       req_ri,
    input  logic       req_ov,
    input  logic       req_sys,
    input  logic       req_bp,
    input  logic       req_adel,
    input  logic       req_ades,
    output logic       hit,
    output logic [4:0] exccode,
    output logic [1:0] badv_sel
);

    always_comb begin
        hit      = 1'b1;
        exccode  = EXC_INT;
        badv_sel = 2'b00;
        if (req_int) begin
            exccode = EXC_INT;
        end else if (req_adel_if) begin
            exccode  = EXC_ADEL;
            badv_sel = 2'b11;
        end else if (req_ri) begin
            exccode = EXC_RI;
        end else if (req_ov) begin
            exccode = EXC_OV;
        end else if (req_sys) begin
            exccode = EXC_SYS;
        end else if (req_bp) begin
            exccode = EXC_BP;
        end else if (req_adel) begin
            exccode  = EXC_ADEL;
            badv_sel = 2'b10;
        end else if (req_ades) begin
            exccode  = EXC_ADES;
            badv_sel = 2'b10;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: accepts one exception or ERET from MEM, issues a
// single-cycle CP0 update while flushing, then redirects fetch.
module exc_ctrl
    import exc_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] RST_PC     = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic [31:0] mem_addr,
    input  logic        req_int,
    input  logic        req_adel_if,
    input  logic        req_ri,
    input  logic        req_ov,
    input  logic        req_sys,
    input  logic        req_bp,
    input  logic        req_adel,
    input  logic        req_ades,
    input  logic        mem_eret,
    input  logic        exl,
    input  logic [31:0] epc_in,
    output logic        exc_hit,
    output logic        busy,
    output logic        flush,
    output logic        cp0_we,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        cp0_epc_we,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_set_exl,
    output logic        cp0_clr_exl,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    // The boot vector is only documentation here; it must still be word aligned.
    if (RST_PC[1:0] != 2'b00) begin : g_bad_rst_pc
        $error("exc_ctrl: RST_PC must be word aligned");
    end

    exc_state_t  state_q, state_d;
    logic        enc_hit;
    logic [4:0]  enc_code;
    logic [1:0]  enc_badv_sel;

    logic        eret_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q;
    logic        bd_q;
    logic [31:0] badv_q;
    logic        badv_we_q;
    logic        epc_we_q;
    logic [31:0] target_q;

    exc_prio_enc u_prio (
        .req_int     (req_int & ~exl),
        .req_adel_if (req_adel_if),
        .req_ri      (req_ri),
        .req_ov      (req_ov),
        .req_sys     (req_sys),
        .req_bp      (req_bp),
        .req_adel    (req_adel),
        .req_ades    (req_ades),
        .hit         (enc_hit),
        .exccode     (enc_code),
        .badv_sel    (enc_badv_sel)
    );

    assign exc_hit = ~rst && (state_q == ST_IDLE) && mem_valid && (enc_hit || mem_eret);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            eret_q    <= 1'b0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
            bd_q      <= 1'b0;
            badv_q    <= 32'd0;
            badv_we_q <= 1'b0;
            epc_we_q  <= 1'b0;
            target_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (exc_hit) begin
                eret_q    <= ~enc_hit;
                exccode_q <= enc_hit ? enc_code : 5'd0;
                epc_q     <= mem_bd ? (mem_pc - 32'd4) : mem_pc;
                bd_q      <= mem_bd;
                badv_q    <= enc_badv_sel[0] ? mem_pc : mem_addr;
                badv_we_q <= enc_hit & enc_badv_sel[1];
                epc_we_q  <= ~exl;
                target_q  <= enc_hit ? EXC_VECTOR : epc_in;
            end
        end
    end

    // Redirect handshake: redirect_valid/redirect_pc stay stable until a rising
    // edge samples redirect_valid && redirect_ready; that edge is the transfer.
    always_comb begin
        state_d        = state_q;
        busy           = 1'b0;
        flush          = 1'b0;
        cp0_we         = 1'b0;
        cp0_exccode    = 5'd0;
        cp0_epc        = 32'd0;
        cp0_bd         = 1'b0;
        cp0_epc_we     = 1'b0;
        cp0_badv_we    = 1'b0;
        cp0_badvaddr   = 32'd0;
        cp0_set_exl    = 1'b0;
        cp0_clr_exl    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (exc_hit) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy         = 1'b1;
                flush        = 1'b1;
                cp0_we       = 1'b1;
                cp0_exccode  = exccode_q;
                cp0_epc      = epc_q;
                cp0_bd       = bd_q;
                cp0_epc_we   = epc_we_q & ~eret_q;
                cp0_badv_we  = badv_we_q & ~eret_q;
                cp0_badvaddr = badv_q;
                cp0_set_exl  = ~eret_q;
                cp0_clr_exl  = eret_q;
                state_d      = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                busy           = 1'b1;
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (redirect_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed cases plus random instruction streams
// checked against a priority-table reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int R_INT = 0, R_ADEL_IF = 1, R_RI = 2, R_OV = 3,
                   R_SYS = 4, R_BP = 5, R_ADEL = 6, R_ADES = 7;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] addr;
        logic [7:0]  reqs;
        logic        eret;
        logic        exl;
        logic [31:0] epc_in;
        logic        ready;
    } instr_t;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        epc_we;
        logic        badv_we;
        logic [31:0] badv;
        logic        eret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_valid = 0, mem_bd = 0, mem_eret = 0, exl = 0, redirect_ready = 0;
    logic [31:0] mem_pc = 0, mem_addr = 0, epc_in = 0;
    logic req_int = 0, req_adel_if = 0, req_ri = 0, req_ov = 0;
    logic req_sys = 0, req_bp = 0, req_adel = 0, req_ades = 0;
    logic exc_hit, busy, flush, cp0_we, cp0_bd, cp0_epc_we, cp0_badv_we;
    logic cp0_set_exl, cp0_clr_exl, redirect_valid;
    logic [4:0] cp0_exccode;
    logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
        .mem_addr(mem_addr), .req_int(req_int), .req_adel_if(req_adel_if), .req_ri(req_ri),
        .req_ov(req_ov), .req_sys(req_sys), .req_bp(req_bp), .req_adel(req_adel),
        .req_ades(req_ades), .mem_eret(mem_eret), .exl(exl), .epc_in(epc_in),
        .exc_hit(exc_hit), .busy(busy), .flush(flush), .cp0_we(cp0_we),
        .cp0_exccode(cp0_exccode), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
        .cp0_epc_we(cp0_epc_we), .cp0_badv_we(cp0_badv_we), .cp0_badvaddr(cp0_badvaddr),
        .cp0_set_exl(cp0_set_exl), .cp0_clr_exl(cp0_clr_exl),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    exp_t        exp_cp0_q[$];
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int m_phase = 0;  // 0 idle, 1 cp0 update cycle, 2 offering redirect

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk();
        instr_t s;
        s.valid = 0; s.pc = 0; s.bd = 0; s.addr = 0; s.reqs = 0;
        s.eret = 0; s.exl = 0; s.epc_in = 0; s.ready = 1;
        return s;
    endfunction

    function automatic logic [7:0] live_reqs(instr_t s);
        logic [7:0] r;
        r = s.reqs;
        if (s.exl) r[R_INT] = 1'b0;
        return r;
    endfunction

    // Reference: first set request in MIPS priority order wins; ERET only if none.
    function automatic exp_t ref_model(instr_t s);
        int        codes[8] = '{0, 4, 10, 12, 8, 9, 4, 5};
        bit        badv[8]  = '{0, 1, 0, 0, 0, 0, 1, 1};
        logic [7:0] r;
        exp_t e;
        r = live_reqs(s);
        e.eret = 1; e.code = 0; e.badv_we = 0; e.badv = 0;
        e.epc = s.bd ? s.pc - 32'd4 : s.pc;
        e.bd = s.bd;
        e.epc_we = !s.exl;
        for (int i = 0; i < 8; i++) begin
            if (e.eret && r[i]) begin
                e.eret = 0;
                e.code = 5'(codes[i]);
                e.badv_we = badv[i];
                e.badv = (i == R_ADEL_IF) ? s.pc : s.addr;
            end
        end
        return e;
    endfunction

    // driver: one instruction per cycle, exc_hit and phase outputs checked #1 later
    task automatic apply(input instr_t s);
        logic exp_hit;
        @(negedge clk);
        mem_valid = s.valid; mem_pc = s.pc; mem_bd = s.bd; mem_addr = s.addr;
        {req_ades, req_adel, req_bp, req_sys, req_ov, req_ri, req_adel_if, req_int} = s.reqs;
        mem_eret = s.eret; exl = s.exl; epc_in = s.epc_in; redirect_ready = s.ready;
        #1;
        exp_hit = (m_phase == 0) && s.valid && ((live_reqs(s) != 0) || s.eret);
        chk("exc_hit", 32'(exc_hit), 32'(exp_hit));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("flush", 32'(flush), 32'(m_phase != 0));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_phase == 2));
        if (exp_hit) begin
            exp_t e;
            e = ref_model(s);
            exp_cp0_q.push_back(e);
            exp_q.push_back(e.eret ? s.epc_in : VEC);
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (m_phase == 2 && s.ready) begin
            m_phase = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; redirect_ready = 0;
        mem_valid = 1; req_sys = 1; req_int = 1; mem_pc = 32'h100; exl = 0;
        #1;
        chk("exc_hit_in_rst", 32'(exc_hit), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_ctrl", {26'd0, busy, flush, cp0_we, redirect_valid, cp0_set_exl, cp0_clr_exl}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_badv", cp0_badvaddr, 32'd0);
        chk("rst_misc", {25'd0, cp0_exccode, cp0_bd, cp0_epc_we | cp0_badv_we}, 32'd0);
        exp_cp0_q.delete();
        exp_q.delete();
        m_phase = 0;
        mem_valid = 0; req_sys = 0; req_int = 0;
        rst = 0;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a CP0 update or a redirect transfer
    logic       prev_we = 0;
    logic       have_prev = 0;
    logic [31:0] prev_pc = 0;
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            prev_we = 0;
            have_prev = 0;
        end else begin
            if (cp0_we) begin
                chk("cp0_we_consecutive", 32'(prev_we), 32'd0);
                if (exp_cp0_q.size() == 0) begin
                    chk("cp0_we_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_cp0_q.pop_front();
                    chk("set_exl", 32'(cp0_set_exl), 32'(!e.eret));
                    chk("clr_exl", 32'(cp0_clr_exl), 32'(e.eret));
                    chk("epc_we", 32'(cp0_epc_we), 32'(e.epc_we && !e.eret));
                    chk("badv_we", 32'(cp0_badv_we), 32'(e.badv_we && !e.eret));
                    if (!e.eret) begin
                        chk("exccode", 32'(cp0_exccode), 32'(e.code));
                        chk("epc", cp0_epc, e.epc);
                        chk("bd", 32'(cp0_bd), 32'(e.bd));
                        if (e.badv_we) chk("badvaddr", cp0_badvaddr, e.badv);
                    end
                end
            end
            prev_we = cp0_we;
            if (redirect_valid) begin
                if (have_prev) chk("redirect_pc_stable", redirect_pc, prev_pc);
                if (redirect_ready) begin
                    if (exp_q.size() == 0) chk("redirect_unexpected", 32'd1, 32'd0);
                    else chk("redirect_pc", redirect_pc, exp_q.pop_front());
                end
                have_prev = !redirect_ready;
                prev_pc = redirect_pc;
            end else begin
                have_prev = 0;
            end
        end
    end

    // stimulus
    initial begin
        instr_t s;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst = 0;

        // overflow, no delay slot
        s = mk(); s.valid = 1; s.pc = 32'h8000_0010; s.reqs[R_OV] = 1;
        apply(s); apply(mk()); apply(mk()); apply(mk());
        // misaligned load in a delay slot
        s = mk(); s.valid = 1; s.pc = 32'h8000_0024; s.bd = 1; s.addr = 32'h1003;
        s.reqs[R_ADEL] = 1;
        apply(s); apply(mk()); apply(mk());
        // int + sys + ri, then the same with exl set
        s = mk(); s.valid = 1; s.pc = 32'h8000_0200;
        s.reqs[R_INT] = 1; s.reqs[R_SYS] = 1; s.reqs[R_RI] = 1;
        apply(s); apply(mk()); apply(mk());
        s.exl = 1;
        apply(s); apply(mk()); apply(mk());
        // ERET
        s = mk(); s.valid = 1; s.pc = 32'h8000_0300; s.eret = 1; s.exl = 1;
        s.epc_in = 32'h8000_0100;
        apply(s); apply(mk()); apply(mk());
        // interrupt beats ERET
        s.exl = 0; s.reqs[R_INT] = 1;
        apply(s); apply(mk()); apply(mk());
        // bubble with requests is not accepted
        s = mk(); s.reqs = 8'hFF; s.eret = 1;
        apply(s);
        // stalled redirect with a fresh syscall arriving
        s = mk(); s.valid = 1; s.pc = 32'h8000_0400; s.reqs[R_SYS] = 1;
        apply(s);
        s.ready = 0;
        repeat (6) apply(s);
        apply(mk());
        // reset mid-redirect, then a fresh syscall at 0x40
        s = mk(); s.valid = 1; s.pc = 32'h8000_1000; s.reqs[R_BP] = 1; s.ready = 0;
        apply(s); apply(s); apply(s);
        do_reset();
        s = mk(); s.valid = 1; s.pc = 32'h40; s.reqs[R_SYS] = 1;
        apply(s); apply(mk()); apply(mk());

        // random instruction stream
        for (int n = 0; n < 600; n++) begin
            s = mk();
            s.valid = ($urandom_range(0, 9) < 8);
            s.pc = {$urandom(), 2'b00} ^ {30'd0, 2'($urandom_range(0, 3) == 0 ? 2'd2 : 2'd0)};
            s.bd = $urandom_range(0, 1);
            s.addr = $urandom();
            for (int b = 0; b < 8; b++) s.reqs[b] = ($urandom_range(0, 9) == 0);
            s.eret = ($urandom_range(0, 6) == 0);
            s.exl = $urandom_range(0, 1);
            s.epc_in = $urandom();
            s.ready = ($urandom_range(0, 9) < 6);
            apply(s);
        end

        // drain
        repeat (8) apply(mk());
        chk("cp0_queue_empty", 32'(exp_cp0_q.size()), 32'd0);
        chk("redirect_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
